// File: rtl/draw_rect_pkg.sv
// Shared types and defaults for the draggable-rectangle motion controller.
package draw_rect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        RISE = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam int FRAC_BITS       = 8;
    localparam int DEF_V_SIZE      = 600;
    localparam int DEF_RECT_HEIGHT = 65;
    localparam int DEF_ACCEL       = 256;

endpackage

// File: rtl/draw_rect_tick.sv
// Free-running strobe divider: one-cycle pulse every DIV clock cycles.
module draw_rect_tick #(
    parameter int DIV = 40000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/draw_rect_ctl.sv
// Rectangle motion controller: follows the mouse in IDLE, drops under gravity on click.
// Define DRAW_RECT_CTL_BOUNCE_EN to enable damped bouncing at the bottom limit.
module draw_rect_ctl
    import draw_rect_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 40_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int RECT_HEIGHT = DEF_RECT_HEIGHT,
    parameter int V_SIZE      = DEF_V_SIZE,
    parameter int ACCEL       = DEF_ACCEL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos
);

    localparam logic [11:0] YMAX    = 12'(V_SIZE - RECT_HEIGHT);
    localparam logic [19:0] YMAX_FX = {YMAX, {FRAC_BITS{1'b0}}};
    localparam logic [19:0] ACC     = 20'(ACCEL);
    localparam logic [19:0] ACC2    = 20'(2 * ACCEL);

    state_t      state, state_nx;
    logic        left_d;
    logic        click;
    logic        tick;
    logic [19:0] y_fx, y_nx;
    logic [19:0] v, v_nx;
    logic [11:0] xpos_nx;
    logic [20:0] y_sum;
    logic [19:0] v_inc;

    draw_rect_tick #(
        .DIV(CLK_FREQ_HZ / TICK_HZ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign click = mouse_left & ~left_d;
    assign y_sum = {1'b0, y_fx} + {1'b0, v};
    assign v_inc = v + ACC;
    assign ypos  = y_fx[19:8];

`ifdef DRAW_RECT_CTL_BOUNCE_EN
    logic [20:0] y_diff;
    assign y_diff = {1'b0, y_fx} - {1'b0, v};

    function automatic logic [19:0] damp(input logic [19:0] vel);
        return vel - (vel >> 2);
    endfunction

    // Upward motion that would cross the top edge stops at line 0.
    function automatic logic [19:0] sat_floor(input logic [20:0] d);
        return d[20] ? 20'd0 : d[19:0];
    endfunction
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            left_d <= 1'b0;
            xpos   <= '0;
            y_fx   <= '0;
            v      <= '0;
        end else begin
            state  <= state_nx;
            left_d <= mouse_left;
            xpos   <= xpos_nx;
            y_fx   <= y_nx;
            v      <= v_nx;
        end
    end

    always_comb begin
        state_nx = state;
        xpos_nx  = xpos;
        y_nx     = y_fx;
        v_nx     = v;
        case (state)
            IDLE: begin
                xpos_nx = mouse_xpos;
                y_nx    = {mouse_ypos, {FRAC_BITS{1'b0}}};
                if (click) begin
                    v_nx = '0;
                    if (mouse_ypos >= YMAX) begin
                        y_nx     = YMAX_FX;
                        state_nx = STOP;
                    end else begin
                        state_nx = FALL;
                    end
                end
            end
            FALL: begin
                if (tick) begin
                    v_nx = v_inc;
                    if (y_sum >= {1'b0, YMAX_FX}) begin
                        y_nx = YMAX_FX;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
                        v_nx     = damp(v_inc);
                        state_nx = (v_nx < ACC2) ? STOP : RISE;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        y_nx = y_sum[19:0];
                    end
                end
            end
`ifdef DRAW_RECT_CTL_BOUNCE_EN
            RISE: begin
                if (tick) begin
                    y_nx = sat_floor(y_diff);
                    // Apex reached once the decremented speed would be <= ACCEL.
                    if (v <= ACC2 || y_diff[20]) begin
                        v_nx     = '0;
                        state_nx = FALL;
                    end else begin
                        v_nx = v - ACC;
                    end
                end
            end
`endif
            STOP: begin
                y_nx = YMAX_FX;
                if (click) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed self-checking bench for draw_rect_ctl (fast tick: 10 clocks per tick).
module tb_draw_rect_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mouse_left = 1'b0;
    logic [11:0] mouse_xpos = '0;
    logic [11:0] mouse_ypos = '0;
    logic [11:0] xpos;
    logic [11:0] ypos;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    localparam int TICK_DIV = 10;
    localparam int YMAX = 535;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    draw_rect_ctl #(
        .CLK_FREQ_HZ(100),
        .TICK_HZ    (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mouse_left (mouse_left),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .xpos       (xpos),
        .ypos       (ypos)
    );

    typedef struct {
        logic [11:0] mx;
        logic [11:0] my;
        logic [11:0] ex;
        logic [11:0] ey;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic click1();
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
        step();
    endtask

    // Drop from IDLE with mouse at (0,0); returns cycles until ypos hits the limit (-1 on timeout).
    task automatic run_drop(input int mid_click, output int cycles, output int mono_bad,
                            output int x_bad);
        int prev;
        prev     = ypos;
        cycles   = -1;
        mono_bad = 0;
        x_bad    = 0;
        mouse_left = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            step();
            if (i == 3) begin
                mouse_left = 1'b0;
                mouse_xpos = 12'd300;
                mouse_ypos = 12'd300;
            end
            if (mid_click > 0 && i == mid_click)     mouse_left = 1'b1;
            if (mid_click > 0 && i == mid_click + 3) mouse_left = 1'b0;
            if (int'(ypos) < prev) mono_bad++;
            if (xpos != 12'd0) x_bad++;
            prev = ypos;
            if (ypos == 12'(YMAX)) begin
                cycles = i;
                break;
            end
        end
        mouse_left = 1'b0;
    endtask

    // Waits until ypos rests at the limit for several ticks; records any excursion above it.
    task automatic wait_settled(output int ok, output int seen_below);
        int stable;
        stable     = 0;
        ok         = 0;
        seen_below = 0;
        for (int i = 0; i < 30000; i++) begin
            step();
            if (ypos < 12'(YMAX)) seen_below = 1;
            if (ypos == 12'(YMAX)) stable++;
            else stable = 0;
            if (stable >= 60) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        int c1, c2, mb, xb, ok, below, phase;

        vecs[0] = '{12'd100,  12'd200,  12'd100,  12'd200};
        vecs[1] = '{12'd0,    12'd0,    12'd0,    12'd0};
        vecs[2] = '{12'd799,  12'd599,  12'd799,  12'd599};
        vecs[3] = '{12'd4095, 12'd4095, 12'd4095, 12'd4095};
        vecs[4] = '{12'd37,   12'd534,  12'd37,   12'd534};

        // Reset holds outputs at zero even with a non-zero mouse.
        mouse_xpos = 12'd55;
        mouse_ypos = 12'd66;
        repeat (3) step();
        check("reset_xpos", xpos, 0);
        check("reset_ypos", ypos, 0);
        mouse_xpos = 12'd0;
        mouse_ypos = 12'd0;
        #2 rst = 1'b1;
        step();
        step();
        check("release_xpos", xpos, 0);
        check("release_ypos", ypos, 0);

        for (int i = 0; i < 5; i++) begin
            mouse_xpos = vecs[i].mx;
            mouse_ypos = vecs[i].my;
            step();
            check($sformatf("follow_x[%0d]", i), xpos, vecs[i].ex);
            check($sformatf("follow_y[%0d]", i), ypos, vecs[i].ey);
        end

        // First drop from the top.
        mouse_xpos = 12'd0;
        mouse_ypos = 12'd0;
        step();
        phase = cyc % TICK_DIV;
        run_drop(0, c1, mb, xb);
        check("drop1_monotonic_violations", mb, 0);
        check("drop1_xpos_moves", xb, 0);
        check_range("drop1_cycles_to_535", c1, 300, 360);

        wait_settled(ok, below);
        check("drop1_settled", ok, 1);
`ifdef DRAW_RECT_CTL_BOUNCE_EN
        check("drop1_bounced", below, 1);
`else
        check("drop1_left_535", below, 0);
`endif
        check("stop_xpos_frozen", xpos, 0);

        // STOP -> IDLE, then IDLE follows again.
        mouse_xpos = 12'd0;
        mouse_ypos = 12'd0;
        click1();
        check("stop_click_ypos", ypos, 0);
        check("stop_click_xpos", xpos, 0);
        mouse_xpos = 12'd123;
        mouse_ypos = 12'd45;
        step();
        check("idle_again_x", xpos, 123);
        check("idle_again_y", ypos, 45);

        // Second drop on the same tick phase; a click mid-fall must not disturb it.
        mouse_xpos = 12'd0;
        mouse_ypos = 12'd0;
        step();
        for (int i = 0; i < TICK_DIV && (cyc % TICK_DIV) != phase; i++) step();
        run_drop(100, c2, mb, xb);
        check("drop2_same_duration", c2, c1);
        check("drop2_monotonic_violations", mb, 0);
        wait_settled(ok, below);
        check("drop2_settled", ok, 1);

        // Click at or below the limit goes straight to STOP.
        mouse_xpos = 12'd0;
        mouse_ypos = 12'd0;
        click1();
        mouse_xpos = 12'd10;
        mouse_ypos = 12'd590;
        step();
        check("deep_idle_y", ypos, 590);
        mouse_left = 1'b1;
        step();
        check("deep_click_ypos", ypos, YMAX);
        check("deep_click_xpos", xpos, 10);
        mouse_left = 1'b0;
        mouse_xpos = 12'd20;
        mouse_ypos = 12'd100;
        repeat (5) step();
        check("deep_hold_ypos", ypos, YMAX);
        check("deep_hold_xpos", xpos, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
